avr_cpu_writeback: RTL and testbench



---
 rtl/avr_cpu_pkg.sv | 13 +
 rtl/avr_cpu_writeback_if.sv | 15 +
 rtl/avr_cpu_wb_bypass.sv | 35 +++
 rtl/avr_cpu_writeback.sv | 104 ++++++++++
 tb/tb_avr_cpu_writeback.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/avr_cpu_pkg.sv
// Shared CPU definitions used by the write-back sequencer and its bypass logic.
package avr_cpu_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } wb_state_t;

    localparam logic [REG_ADDR_W-1:0] REG_Z_LO = 5'd30;
endpackage

// File: rtl/avr_cpu_writeback_if.sv
// Result handshake between execute/load units and the write-back sequencer.
interface avr_cpu_writeback_if
    import avr_cpu_pkg::*;
();
    logic                    req_valid;
    logic                    req_ready;
    logic [REG_ADDR_W-1:0]   req_addr;
    logic [2*REG_DATA_W-1:0] req_data;
    logic                    req_word;

    modport master (output req_valid, output req_addr, output req_data, output req_word,
                    input  req_ready);
    modport slave  (input  req_valid, input  req_addr, input  req_data, input  req_word,
                    output req_ready);
endinterface

// File: rtl/avr_cpu_wb_bypass.sv
// Matches a decode read address against in-flight register writes.
// Only compiled when AVR_WB_BYPASS_EN is defined.
`ifdef AVR_WB_BYPASS_EN
module avr_cpu_wb_bypass
    import avr_cpu_pkg::*;
(
    input  wb_state_t             i_state,
    input  logic                  i_cur_word,
    input  logic [REG_ADDR_W-1:0] i_rf_addr,
    input  logic [REG_DATA_W-1:0] i_rf_data,
    input  logic [REG_DATA_W-1:0] i_hi_byte,
    input  logic [REG_ADDR_W-1:0] i_byp_addr,
    output logic                  o_hit,
    output logic [REG_DATA_W-1:0] o_data
);
    logic [REG_ADDR_W-1:0] w_odd_addr;

    assign w_odd_addr = {i_rf_addr[REG_ADDR_W-1:1], 1'b1};

    // The write currently on the port wins over the still-pending high byte.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        if (i_state != IDLE) begin
            if (i_byp_addr == i_rf_addr) begin
                o_hit  = 1'b1;
                o_data = i_rf_data;
            end else if (i_state == LO && i_cur_word && i_byp_addr == w_odd_addr) begin
                o_hit  = 1'b1;
                o_data = i_hi_byte;
            end
        end
    end
endmodule
`endif

// File: rtl/avr_cpu_writeback.sv
// Write-back sequencer: turns byte/word results into single-byte register file writes.
// Optional read-bypass of in-flight data is enabled by defining AVR_WB_BYPASS_EN.
module avr_cpu_writeback
    import avr_cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    avr_cpu_writeback_if.slave    req,
    output logic                  rf_write,
    output logic [REG_ADDR_W-1:0] rf_addr,
    output logic [REG_DATA_W-1:0] rf_data,
    output logic                  busy,
    input  logic [REG_ADDR_W-1:0] byp_addr,
    output logic                  byp_hit,
    output logic [REG_DATA_W-1:0] byp_data
);
    wb_state_t             r_state,     w_state_next;
    logic                  r_cur_word,  w_cur_word_next;
    logic [REG_DATA_W-1:0] r_hi_byte,   w_hi_byte_next;
    logic                  r_rf_write,  w_rf_write_next;
    logic [REG_ADDR_W-1:0] r_rf_addr,   w_rf_addr_next;
    logic [REG_DATA_W-1:0] r_rf_data,   w_rf_data_next;
    logic                  w_ready;
    logic                  w_accept;
    logic [REG_ADDR_W-1:0] w_load_addr;

    // A word's second byte must follow its first, so only a byte in flight can overlap a new request.
    assign w_ready     = (r_state == IDLE) || (r_state == LO && !r_cur_word);
    assign w_accept    = req.req_valid && w_ready;
    assign w_load_addr = req.req_word ? {req.req_addr[REG_ADDR_W-1:1], 1'b0} : req.req_addr;

    always_comb begin
        w_state_next    = r_state;
        w_cur_word_next = r_cur_word;
        w_hi_byte_next  = r_hi_byte;
        w_rf_write_next = 1'b0;
        w_rf_addr_next  = r_rf_addr;
        w_rf_data_next  = r_rf_data;
        case (r_state)
            LO: begin
                if (r_cur_word) begin
                    w_state_next    = HI;
                    w_rf_write_next = 1'b1;
                    w_rf_addr_next  = {r_rf_addr[REG_ADDR_W-1:1], 1'b1};
                    w_rf_data_next  = r_hi_byte;
                end else if (!w_accept) begin
                    w_state_next = IDLE;
                end
            end
            HI:      w_state_next = IDLE;
            default: ;
        endcase
        if (w_accept) begin
            w_state_next    = LO;
            w_cur_word_next = req.req_word;
            w_hi_byte_next  = req.req_data[2*REG_DATA_W-1:REG_DATA_W];
            w_rf_write_next = 1'b1;
            w_rf_addr_next  = w_load_addr;
            w_rf_data_next  = req.req_data[REG_DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cur_word <= 1'b0;
            r_hi_byte  <= '0;
            r_rf_write <= 1'b0;
            r_rf_addr  <= '0;
            r_rf_data  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_cur_word <= w_cur_word_next;
            r_hi_byte  <= w_hi_byte_next;
            r_rf_write <= w_rf_write_next;
            r_rf_addr  <= w_rf_addr_next;
            r_rf_data  <= w_rf_data_next;
        end
    end

    assign req.req_ready = w_ready;
    assign rf_write      = r_rf_write;
    assign rf_addr       = r_rf_addr;
    assign rf_data       = r_rf_data;
    assign busy          = (r_state != IDLE);

`ifdef AVR_WB_BYPASS_EN
    avr_cpu_wb_bypass u_bypass (
        .i_state    (r_state),
        .i_cur_word (r_cur_word),
        .i_rf_addr  (r_rf_addr),
        .i_rf_data  (r_rf_data),
        .i_hi_byte  (r_hi_byte),
        .i_byp_addr (byp_addr),
        .o_hit      (byp_hit),
        .o_data     (byp_data)
    );
`else
    logic w_unused_byp;
    assign w_unused_byp = ^byp_addr;
    assign byp_hit      = 1'b0;
    assign byp_data     = '0;
`endif
endmodule

// File: tb/tb_avr_cpu_writeback.sv
// Directed vector table, mid-word reset sequence and randomized run against a write-queue model.
module tb_avr_cpu_writeback;
    import avr_cpu_pkg::*;

`ifdef AVR_WB_BYPASS_EN
    localparam bit BYP_ON = 1'b1;
`else
    localparam bit BYP_ON = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       rf_write;
    logic [4:0] rf_addr;
    logic [7:0] rf_data;
    logic       busy;
    logic [4:0] byp_addr;
    logic       byp_hit;
    logic [7:0] byp_data;

    avr_cpu_writeback_if wb();

    avr_cpu_writeback dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (wb),
        .rf_write (rf_write),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data),
        .busy     (busy),
        .byp_addr (byp_addr),
        .byp_hit  (byp_hit),
        .byp_data (byp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: a queue of byte writes still to appear on the port, plus the one showing now.
    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
        bit         w;
    } wr_t;

    wr_t        fut[$];
    wr_t        cur;
    bit         cur_v;
    logic [4:0] last_a;
    logic [7:0] last_d;

    function automatic bit m_ready();
        return !cur_v || !cur.w;
    endfunction

    task automatic m_reset();
        fut.delete();
        cur_v  = 1'b0;
        cur    = '{a: 5'd0, d: 8'd0, w: 1'b0};
        last_a = 5'd0;
        last_d = 8'd0;
    endtask

    task automatic m_edge(logic v, logic [4:0] a, logic [15:0] d, logic w);
        if (v && m_ready()) begin
            if (w) begin
                fut.push_back('{a: {a[4:1], 1'b0}, d: d[7:0],  w: 1'b1});
                fut.push_back('{a: {a[4:1], 1'b1}, d: d[15:8], w: 1'b1});
            end else begin
                fut.push_back('{a: a, d: d[7:0], w: 1'b0});
            end
        end
        if (fut.size() > 0) begin
            cur    = fut.pop_front();
            cur_v  = 1'b1;
            last_a = cur.a;
            last_d = cur.d;
        end else begin
            cur_v = 1'b0;
        end
    endtask

    task automatic m_check(string tag);
        bit         ehit;
        logic [7:0] ed;
        ehit = 1'b0;
        ed   = 8'd0;
        if (BYP_ON) begin
            if (cur_v && byp_addr == cur.a) begin
                ehit = 1'b1; ed = cur.d;
            end else if (fut.size() > 0 && byp_addr == fut[0].a) begin
                ehit = 1'b1; ed = fut[0].d;
            end
        end
        chk({tag, " rf_write"}, int'(rf_write), int'(cur_v));
        chk({tag, " rf_addr"},  int'(rf_addr),  int'(last_a));
        chk({tag, " rf_data"},  int'(rf_data),  int'(last_d));
        chk({tag, " ready"},    int'(wb.req_ready), int'(m_ready()));
        chk({tag, " busy"},     int'(busy),     int'(cur_v));
        chk({tag, " byp_hit"},  int'(byp_hit),  int'(ehit));
        if (ehit) chk({tag, " byp_data"}, int'(byp_data), int'(ed));
    endtask

    // Drive at a falling edge, advance through one rising edge, return at the next falling edge.
    task automatic step(logic v, logic [4:0] a, logic [15:0] d, logic w, logic [4:0] ba);
        wb.req_valid = v;
        wb.req_addr  = a;
        wb.req_data  = d;
        wb.req_word  = w;
        byp_addr     = ba;
        m_edge(v, a, d, w);
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        v;
        logic [4:0]  a;
        logic [15:0] d;
        logic        w;
        logic [4:0]  ba;
        logic        e_wr;
        logic [4:0]  e_a;
        logic [7:0]  e_d;
        logic        e_rdy;
        logic        e_busy;
        logic        e_hit;
        logic [7:0]  e_bd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(int v, int a, int d, int w, int ba,
                       int ewr, int ea, int ed, int erdy, int ebusy, int ehit, int ebd);
        vec_t t;
        t.v = 1'(v);      t.a = 5'(a);     t.d = 16'(d);     t.w = 1'(w);
        t.ba = 5'(ba);    t.e_wr = 1'(ewr); t.e_a = 5'(ea);  t.e_d = 8'(ed);
        t.e_rdy = 1'(erdy); t.e_busy = 1'(ebusy); t.e_hit = 1'(ehit); t.e_bd = 8'(ebd);
        vecs.push_back(t);
    endtask

    initial begin
        rst_n        = 1'b0;
        wb.req_valid = 1'b0;
        wb.req_addr  = 5'd0;
        wb.req_data  = 16'd0;
        wb.req_word  = 1'b0;
        byp_addr     = 5'd0;
        m_reset();

        //  v  addr  data     w  byp | wr addr data rdy busy hit bdata (state after the edge)
        add(1, 5,  16'h00A7, 0, 0,    1, 5,  8'hA7, 1, 1, 0, 0);
        add(0, 0,  0,        0, 0,    0, 5,  8'hA7, 1, 0, 0, 0);
        add(1, int'(REG_Z_LO), 16'h1234, 1, 0, 1, 30, 8'h34, 0, 1, 0, 0);
        add(0, 0,  0,        0, 0,    1, 31, 8'h12, 0, 1, 0, 0);
        add(0, 0,  0,        0, 0,    0, 31, 8'h12, 1, 0, 0, 0);
        add(1, 25, 16'hBEEF, 1, 0,    1, 24, 8'hEF, 0, 1, 0, 0);
        add(1, 7,  16'h0055, 0, 0,    1, 25, 8'hBE, 0, 1, 0, 0);
        add(1, 7,  16'h0055, 0, 0,    0, 25, 8'hBE, 1, 0, 0, 0);
        add(1, 7,  16'h0055, 0, 0,    1, 7,  8'h55, 1, 1, 0, 0);
        add(1, 1,  16'h0011, 0, 0,    1, 1,  8'h11, 1, 1, 0, 0);
        add(1, 2,  16'h0022, 0, 0,    1, 2,  8'h22, 1, 1, 0, 0);
        add(1, 3,  16'h0033, 0, 0,    1, 3,  8'h33, 1, 1, 0, 0);
        add(0, 0,  0,        0, 0,    0, 3,  8'h33, 1, 0, 0, 0);
        add(1, 10, 16'h0044, 0, 0,    1, 10, 8'h44, 1, 1, 0, 0);
        add(1, 12, 16'hCDAB, 1, 0,    1, 12, 8'hAB, 0, 1, 0, 0);
        add(0, 0,  0,        0, 0,    1, 13, 8'hCD, 0, 1, 0, 0);
        add(0, 0,  0,        0, 0,    0, 13, 8'hCD, 1, 0, 0, 0);
        add(1, 28, 16'h9988, 1, 29,   1, 28, 8'h88, 0, 1, 1, 8'h99);
        add(0, 0,  0,        0, 29,   1, 29, 8'h99, 0, 1, 1, 8'h99);
        add(0, 0,  0,        0, 29,   0, 29, 8'h99, 1, 0, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset rf_write", int'(rf_write), 0);
        chk("reset rf_addr",  int'(rf_addr),  0);
        chk("reset rf_data",  int'(rf_data),  0);
        chk("reset busy",     int'(busy),     0);
        chk("reset byp_hit",  int'(byp_hit),  0);
        chk("reset ready",    int'(wb.req_ready), 1);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            string tg;
            tg = $sformatf("vec%0d", i);
            step(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].w, vecs[i].ba);
            chk({tg, " rf_write"}, int'(rf_write), int'(vecs[i].e_wr));
            chk({tg, " rf_addr"},  int'(rf_addr),  int'(vecs[i].e_a));
            chk({tg, " rf_data"},  int'(rf_data),  int'(vecs[i].e_d));
            chk({tg, " ready"},    int'(wb.req_ready), int'(vecs[i].e_rdy));
            chk({tg, " busy"},     int'(busy),     int'(vecs[i].e_busy));
            chk({tg, " byp_hit"},  int'(byp_hit),  BYP_ON ? int'(vecs[i].e_hit) : 0);
            if (BYP_ON && vecs[i].e_hit)
                chk({tg, " byp_data"}, int'(byp_data), int'(vecs[i].e_bd));
            $display("[TB] vec%0d v=%0d a=%0d d=%h w=%0d -> wr=%0d a=%0d d=%h rdy=%0d",
                     i, vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].w,
                     rf_write, rf_addr, rf_data, wb.req_ready);
        end

        // Reset in the low-byte cycle of a word: the high byte must never reach the port.
        step(1'b1, 5'd26, 16'h5566, 1'b1, 5'd0);
        chk("midrst lo write", int'(rf_write), 1);
        chk("midrst lo addr",  int'(rf_addr),  26);
        chk("midrst lo data",  int'(rf_data),  8'h66);
        wb.req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst rf_write", int'(rf_write), 0);
        chk("midrst rf_addr",  int'(rf_addr),  0);
        chk("midrst rf_data",  int'(rf_data),  0);
        chk("midrst busy",     int'(busy),     0);
        chk("midrst byp_hit",  int'(byp_hit),  0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 5'd0, 16'd0, 1'b0, 5'd27);
            chk("postrst no write", int'(rf_write), 0);
            chk("postrst addr",     int'(rf_addr),  0);
            chk("postrst ready",    int'(wb.req_ready), 1);
            $display("[TB] postrst cycle%0d wr=%0d a=%0d rdy=%0d", i, rf_write, rf_addr, wb.req_ready);
        end

        for (int i = 0; i < 400; i++) begin
            logic        v, w;
            logic [4:0]  a, ba;
            logic [15:0] d;
            v  = 1'($urandom_range(0, 3) != 0);
            w  = 1'($urandom_range(0, 1));
            a  = 5'($urandom_range(0, 7));
            ba = 5'($urandom_range(0, 7));
            d  = 16'($urandom);
            step(v, a, d, w, ba);
            m_check($sformatf("rnd%0d", i));
            $display("[TB] rnd%0d v=%0d a=%0d d=%h w=%0d ba=%0d -> wr=%0d a=%0d d=%h hit=%0d",
                     i, v, a, d, w, ba, rf_write, rf_addr, rf_data, byp_hit);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
